// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter: round-robin read / fixed-priority write arbiter for a 1R1W register bank
module regfile_port_arbiter #(
  parameter int N_RD = 4,
  parameter int N_WR = 2,
  parameter int AW   = 9,
  parameter int DW   = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_RD-1:0]   rd_req_valid,
  output logic [N_RD-1:0]   rd_req_ready,
  input  logic [N_RD*AW-1:0] rd_req_addr,
  output logic [N_RD-1:0]   rd_rsp_valid,
  output logic [DW-1:0]     rd_rsp_data,
  input  logic [N_WR-1:0]   wr_req_valid,
  output logic [N_WR-1:0]   wr_req_ready,
  input  logic [N_WR*AW-1:0] wr_req_addr,
  input  logic [N_WR*DW-1:0] wr_req_data,
  output logic              mem_R0_en,
  output logic [AW-1:0]     mem_R0_addr,
  input  logic [DW-1:0]     mem_R0_data,
  output logic              mem_W0_en,
  output logic [AW-1:0]     mem_W0_addr,
  output logic [DW-1:0]     mem_W0_data,
  output logic [15:0]       perf_conflict_cnt
);
  localparam int PW = N_RD > 1 ? $clog2(N_RD) : 1;
  localparam int QW = N_WR > 1 ? $clog2(N_WR) : 1;
  logic [PW-1:0]   r_rr_ptr;
  logic [N_RD-1:0] r_rsp_valid;
  logic [15:0]     r_conflict_cnt;
  logic            w_rd_any;
  logic [PW-1:0]   w_rd_idx;
  logic [N_RD-1:0] w_rd_gnt;
  logic            w_wr_any;
  logic [QW-1:0]   w_wr_idx;
  logic [N_WR-1:0] w_wr_gnt;
  // first valid reader at or after the round-robin pointer; nothing is granted in reset
  always_comb begin
    w_rd_any = 1'b0;
    w_rd_idx = '0;
    w_rd_gnt = '0;
    for (int k = 0; k < N_RD; k++) begin
      if (!w_rd_any && rd_req_valid[(int'(r_rr_ptr) + k) % N_RD]) begin
        w_rd_any = 1'b1;
        w_rd_idx = PW'((int'(r_rr_ptr) + k) % N_RD);
      end
    end
    w_rd_any = w_rd_any & ~reset;
    if (w_rd_any) w_rd_gnt[w_rd_idx] = 1'b1;
  end
  // lowest-index writer wins; nothing is granted in reset
  always_comb begin
    w_wr_any = 1'b0;
    w_wr_idx = '0;
    w_wr_gnt = '0;
    for (int k = 0; k < N_WR; k++) begin
      if (!w_wr_any && wr_req_valid[k]) begin
        w_wr_any = 1'b1;
        w_wr_idx = QW'(k);
      end
    end
    w_wr_any = w_wr_any & ~reset;
    if (w_wr_any) w_wr_gnt[w_wr_idx] = 1'b1;
  end
  assign rd_req_ready      = w_rd_gnt;
  assign mem_R0_en         = w_rd_any;
  assign mem_R0_addr       = w_rd_any ? rd_req_addr[int'(w_rd_idx)*AW +: AW] : '0;
  assign rd_rsp_valid      = r_rsp_valid;
  assign rd_rsp_data       = mem_R0_data;
  assign wr_req_ready      = w_wr_gnt;
  assign mem_W0_en         = w_wr_any;
  assign mem_W0_addr       = w_wr_any ? wr_req_addr[int'(w_wr_idx)*AW +: AW] : '0;
  assign mem_W0_data       = w_wr_any ? wr_req_data[int'(w_wr_idx)*DW +: DW] : '0;
  assign perf_conflict_cnt = r_conflict_cnt;
  // response strobe one cycle after the grant, pointer advance past the winner, saturating conflict count
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rr_ptr       <= '0;
      r_rsp_valid    <= '0;
      r_conflict_cnt <= '0;
    end else begin
      r_rsp_valid <= w_rd_gnt;
      if (w_rd_any) r_rr_ptr <= PW'((int'(w_rd_idx) + 1) % N_RD);
      if ($countones(rd_req_valid) > 1 && r_conflict_cnt != 16'hFFFF) r_conflict_cnt <= r_conflict_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb_regfile_port_arbiter: vector table plus per-cycle reference model and response scoreboard
module tb_regfile_port_arbiter;
  localparam int N_RD = 4;
  localparam int N_WR = 2;
  localparam int AW   = 9;
  localparam int DW   = 32;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [N_RD-1:0]    rd_req_valid, rd_req_ready, rd_rsp_valid;
  logic [N_RD*AW-1:0] rd_req_addr;
  logic [DW-1:0]      rd_rsp_data;
  logic [N_WR-1:0]    wr_req_valid, wr_req_ready;
  logic [N_WR*AW-1:0] wr_req_addr;
  logic [N_WR*DW-1:0] wr_req_data;
  logic               mem_R0_en, mem_W0_en;
  logic [AW-1:0]      mem_R0_addr, mem_W0_addr;
  logic [DW-1:0]      mem_R0_data, mem_W0_data;
  logic [15:0]        perf_conflict_cnt;
  regfile_port_arbiter #(.N_RD(N_RD), .N_WR(N_WR), .AW(AW), .DW(DW)) dut (
    .clock(clock), .reset(reset),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
    .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
    .mem_R0_en(mem_R0_en), .mem_R0_addr(mem_R0_addr), .mem_R0_data(mem_R0_data),
    .mem_W0_en(mem_W0_en), .mem_W0_addr(mem_W0_addr), .mem_W0_data(mem_W0_data),
    .perf_conflict_cnt(perf_conflict_cnt)
  );
  always #5 clock = ~clock;
  int n_tests = 0;
  int n_fail  = 0;
  bit mon_on  = 1'b0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [31:0] init_val(input int a);
    return (a == 32'h0A5) ? 32'hDEADBEEF : (32'hA000_0000 | 32'(a));
  endfunction
  // 1R1W bank with 1-cycle read latency; a same-cycle write is visible to the read
  logic [DW-1:0] mem [512];
  logic [DW-1:0] mem_rd;
  assign mem_R0_data = mem_rd;
  always @(posedge clock) begin
    if (reset) begin
      for (int a = 0; a < 512; a++) mem[a] <= init_val(a);
      mem_rd <= '0;
    end else begin
      if (mem_W0_en) mem[mem_W0_addr] <= mem_W0_data;
      if (mem_R0_en) mem_rd <= (mem_W0_en && mem_W0_addr == mem_R0_addr) ? mem_W0_data : mem[mem_R0_addr];
    end
  end
  // reference model and response scoreboard, evaluated on the falling edge
  typedef struct { int idx; logic [31:0] data; } rsp_t;
  rsp_t q[$];
  logic [31:0] ref_mem [512];
  int m_ptr = 0;
  logic [15:0] m_cnt = '0;
  always @(negedge clock) begin : mon
    int gi, wi, gs, ws;
    logic [AW-1:0] ra, wa;
    logic [DW-1:0] wd;
    rsp_t e;
    if (mon_on) begin
      gi = -1;
      wi = -1;
      if (!reset) begin
        for (int k = 0; k < N_RD; k++)
          if (gi < 0 && rd_req_valid[(m_ptr + k) % N_RD]) gi = (m_ptr + k) % N_RD;
        wi = wr_req_valid[0] ? 0 : (wr_req_valid[1] ? 1 : -1);
      end
      gs = gi < 0 ? 0 : gi;
      ws = wi < 0 ? 0 : wi;
      ra = gi >= 0 ? rd_req_addr[gs*AW +: AW] : '0;
      wa = wi >= 0 ? wr_req_addr[ws*AW +: AW] : '0;
      wd = wi >= 0 ? wr_req_data[ws*DW +: DW] : '0;
      chk("rd_ready", rd_req_ready, gi >= 0 ? 32'(1 << gi) : 32'd0);
      chk("wr_ready", wr_req_ready, wi >= 0 ? 32'(1 << wi) : 32'd0);
      chk("r0_en", mem_R0_en, gi >= 0 ? 32'd1 : 32'd0);
      chk("r0_addr", mem_R0_addr, ra);
      chk("w0_en", mem_W0_en, wi >= 0 ? 32'd1 : 32'd0);
      chk("w0_addr", mem_W0_addr, wa);
      chk("w0_data", mem_W0_data, wd);
      chk("perf", perf_conflict_cnt, m_cnt);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rsp_valid", rd_rsp_valid, 32'(1 << e.idx));
        chk("rsp_data", rd_rsp_data, e.data);
      end else chk("rsp_idle", rd_rsp_valid, 32'd0);
      if (gi >= 0) q.push_back('{gi, (wi >= 0 && wa == ra) ? wd : ref_mem[ra]});
      if (reset) for (int a = 0; a < 512; a++) ref_mem[a] = init_val(a);
      else if (wi >= 0) ref_mem[wa] = wd;
      m_ptr = reset ? 0 : (gi >= 0 ? (gi + 1) % N_RD : m_ptr);
      m_cnt = reset ? 16'd0 : (($countones(rd_req_valid) > 1 && m_cnt != 16'hFFFF) ? m_cnt + 16'd1 : m_cnt);
    end
  end
  typedef struct { logic [3:0] rv; logic [1:0] wv; logic [3:0] er; logic [1:0] ew; } vec_t;
  vec_t tbl [16];
  task automatic step(input logic rs, input logic [3:0] rv, input logic [1:0] wv);
    @(posedge clock);
    #1;
    reset = rs;
    rd_req_valid = rv;
    wr_req_valid = wv;
    @(negedge clock);
  endtask
  initial begin
    rd_req_valid = '0;
    wr_req_valid = '0;
    rd_req_addr  = {9'h0A8, 9'h0A7, 9'h0A6, 9'h0A5};
    wr_req_addr  = {9'h020, 9'h010};
    wr_req_data  = {32'h22222222, 32'h11111111};
    tbl[0]  = '{4'b1111, 2'b11, 4'b0001, 2'b01};
    tbl[1]  = '{4'b1111, 2'b10, 4'b0010, 2'b10};
    tbl[2]  = '{4'b1111, 2'b01, 4'b0100, 2'b01};
    tbl[3]  = '{4'b1111, 2'b00, 4'b1000, 2'b00};
    tbl[4]  = '{4'b1111, 2'b00, 4'b0001, 2'b00};
    tbl[5]  = '{4'b1111, 2'b00, 4'b0010, 2'b00};
    tbl[6]  = '{4'b1111, 2'b00, 4'b0100, 2'b00};
    tbl[7]  = '{4'b1111, 2'b00, 4'b1000, 2'b00};
    tbl[8]  = '{4'b0010, 2'b00, 4'b0010, 2'b00};
    tbl[9]  = '{4'b1010, 2'b00, 4'b1000, 2'b00};
    tbl[10] = '{4'b1010, 2'b00, 4'b0010, 2'b00};
    tbl[11] = '{4'b1010, 2'b00, 4'b1000, 2'b00};
    tbl[12] = '{4'b0100, 2'b00, 4'b0100, 2'b00};
    tbl[13] = '{4'b0100, 2'b10, 4'b0100, 2'b10};
    tbl[14] = '{4'b0000, 2'b00, 4'b0000, 2'b00};
    tbl[15] = '{4'b0001, 2'b00, 4'b0001, 2'b00};
    @(posedge clock);
    mon_on = 1'b1;
    step(1'b1, 4'b1111, 2'b11);
    chk("rst_rd_ready", rd_req_ready, 32'd0);
    chk("rst_wr_ready", wr_req_ready, 32'd0);
    chk("rst_r0_en", mem_R0_en, 32'd0);
    chk("rst_w0_en", mem_W0_en, 32'd0);
    chk("rst_perf", perf_conflict_cnt, 32'd0);
    step(1'b0, 4'b0001, 2'b00);
    chk("single_ready", rd_req_ready, 32'b0001);
    chk("single_addr", mem_R0_addr, 32'h0A5);
    step(1'b0, 4'b0000, 2'b00);
    chk("single_rsp_valid", rd_rsp_valid, 32'b0001);
    chk("single_rsp_data", rd_rsp_data, 32'hDEADBEEF);
    step(1'b1, 4'b0000, 2'b00);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, tbl[i].rv, tbl[i].wv);
      chk($sformatf("tbl%0d_rd_ready", i), rd_req_ready, tbl[i].er);
      chk($sformatf("tbl%0d_wr_ready", i), wr_req_ready, tbl[i].ew);
      if (i == 7) begin
        step(1'b0, 4'b0000, 2'b00);
        chk("rr_perf8", perf_conflict_cnt, 32'd8);
      end
    end
    rd_req_addr[8:0] = 9'h010;
    step(1'b0, 4'b0001, 2'b11);
    chk("col_wr_ready", wr_req_ready, 32'b01);
    chk("col_rd_ready", rd_req_ready, 32'b0001);
    step(1'b0, 4'b0000, 2'b10);
    chk("col_rsp_valid", rd_rsp_valid, 32'b0001);
    chk("col_rsp_data", rd_rsp_data, 32'h11111111);
    chk("col_wr1_ready", wr_req_ready, 32'b10);
    chk("col_w0_addr", mem_W0_addr, 32'h020);
    chk("col_w0_data", mem_W0_data, 32'h22222222);
    step(1'b0, 4'b0000, 2'b00);
    step(1'b0, 4'b0100, 2'b00);
    chk("mid_grant", rd_req_ready, 32'b0100);
    step(1'b1, 4'b1111, 2'b11);
    chk("mid_rsp_shown", rd_rsp_valid, 32'b0100);
    chk("mid_rd_ready_rst", rd_req_ready, 32'd0);
    chk("mid_wr_ready_rst", wr_req_ready, 32'd0);
    step(1'b1, 4'b1111, 2'b11);
    chk("mid_rsp_cleared", rd_rsp_valid, 32'd0);
    chk("mid_rd_ready_rst2", rd_req_ready, 32'd0);
    step(1'b0, 4'b1111, 2'b00);
    chk("mid_ptr_zero", rd_req_ready, 32'b0001);
    step(1'b1, 4'b0000, 2'b00);
    step(1'b0, 4'b1111, 2'b00);
    repeat (65534) @(posedge clock);
    @(negedge clock);
    chk("sat_fffe", perf_conflict_cnt, 32'hFFFE);
    repeat (4466) @(posedge clock);
    @(negedge clock);
    chk("sat_ffff", perf_conflict_cnt, 32'hFFFF);
    repeat (3) step(1'b0, 4'b1111, 2'b00);
    chk("sat_hold", perf_conflict_cnt, 32'hFFFF);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_port_arbiter.md
REGFILE_PORT_ARBITER -- requirements
Module: regfile_port_arbiter

Interface
REQ-001 SHALL have parameter N_RD, default 4, number of read requesters (operand collectors).
REQ-002 SHALL have parameter N_WR, default 2, number of writeback requesters.
REQ-003 SHALL have parameter AW, default 9, bank address width: {wid[2:0], ridx[5:0]}.
REQ-004 SHALL have parameter DW, default 32, data width.
REQ-005 SHALL have port clock  in  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port rd_req_valid  in  N_RD  per-requester read request.
REQ-008 SHALL have port rd_req_ready  out  N_RD  per-requester grant, one-hot or zero.
REQ-009 SHALL have port rd_req_addr  in  N_RD*AW  packed read addresses; requester i at [i*AW +: AW].
REQ-010 SHALL have port rd_rsp_valid  out  N_RD  one-hot response strobe.
REQ-011 SHALL have port rd_rsp_data  out  DW  response data, shared by all requesters.
REQ-012 SHALL have port wr_req_valid  in  N_WR  writeback request.
REQ-013 SHALL have port wr_req_ready  out  N_WR  writeback grant.
REQ-014 SHALL have port wr_req_addr  in  N_WR*AW  packed write addresses.
REQ-015 SHALL have port wr_req_data  in  N_WR*DW  packed write data.
REQ-016 SHALL have ports mem_R0_en (out, 1), mem_R0_addr (out, AW), mem_R0_data (in, DW), which drive the 1R1W bank read port.
REQ-017 SHALL have ports mem_W0_en (out, 1), mem_W0_addr (out, AW), mem_W0_data (out, DW), which drive the bank write port.
REQ-018 SHALL have port perf_conflict_cnt  out  16  saturating count of read-conflict cycles.

Function
REQ-019 SHALL grant at most one read per cycle: rd_req_ready[i]=1 iff rd_req_valid[i]=1, i is the first valid requester at or after rr_ptr (mod N_RD), and reset=0.
REQ-020 SHALL compute rd_req_ready combinationally from rd_req_valid and rr_ptr; a handshake is valid&ready in the same cycle.
REQ-021 SHALL drive mem_R0_en=1 and mem_R0_addr=rd_req_addr[granted] in the grant cycle T; otherwise mem_R0_en=0 and mem_R0_addr=0.
REQ-022 SHALL register the granted index and assert rd_rsp_valid[granted]=1 in cycle T+1 only; read latency is exactly 1 cycle.
REQ-023 SHALL drive rd_rsp_data=mem_R0_data unregistered in every cycle; the value is defined only when any rd_rsp_valid bit is 1.
REQ-024 SHALL provide no response backpressure; requesters sample rd_rsp_data in the strobe cycle.
REQ-025 SHALL update rr_ptr after a grant to i to (i+1) mod N_RD, and hold rr_ptr when there is no grant.
REQ-026 SHALL sustain back-to-back grants at 1 per cycle with no bubble, including repeat grants to the same lone requester.
REQ-027 SHALL grant writes by fixed priority (lowest index wins) at 1 per cycle: mem_W0_en=|wr_req_valid, with mem_W0_addr and mem_W0_data taken from the winner, and zeros otherwise.
REQ-028 SHALL keep the read and write paths independent; a read and a write to the same address in the same cycle T returns the newly written data at T+1, with no bypass logic needed.
REQ-029 SHALL increment perf_conflict_cnt by 1 in each cycle with two or more rd_req_valid bits set, and saturate it at 0xFFFF.
REQ-030 SHALL be fully deterministic: no X on any output after the first reset cycle.

Reset
REQ-031 SHALL, while reset=1, force rd_req_ready=0, wr_req_ready=0, mem_R0_en=0, mem_W0_en=0 combinationally, so no request is accepted.
REQ-032 SHALL, on a reset edge, set rr_ptr=0, rd_rsp_valid=0 and perf_conflict_cnt=0, and drop any in-flight response.
REQ-033 SHALL, when reset is asserted in cycle T+1 after a grant at T, still show that cycle's rd_rsp_valid; it is cleared from T+2.
REQ-034 SHALL, in the first cycle after reset deasserts, give requester 0 highest read priority.

Verification
REQ-035 SHALL cover single read: after reset, rd_req_valid=0001 with addr 0x0A5 and bank[0x0A5]=0xDEADBEEF -> ready=0001 at T, mem_R0_addr=0x0A5, then rd_rsp_valid=0001 and rd_rsp_data=0xDEADBEEF at T+1.
REQ-036 SHALL cover round-robin: all 4 requesters held valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3 and perf_conflict_cnt=8.
REQ-037 SHALL cover skip: valid=1010 after a grant to requester 1 -> grant to 3, then 1, then 3.
REQ-038 SHALL cover write priority and collision: both writers valid, wr0 to 0x010=0x11111111 and wr1 to 0x020=0x22222222, plus a read of 0x010 in the same cycle -> wr_req_ready=01, response 0x11111111; then wr1 is granted next cycle.
REQ-039 SHALL cover reset mid-operation: a grant at T and reset at T+1 for 2 cycles -> rd_rsp_valid shown at T+1, then 0; all readies 0 during reset; rr_ptr=0 afterwards.
REQ-040 SHALL cover saturation: 70000 conflict cycles -> perf_conflict_cnt=0xFFFF and it does not wrap.
